// File: rtl/msix_msg_writer_if.sv
// msix_msg_writer_if: 32-bit TLP stream carrying MSI-X MWr beats (tdata/tvalid/tready/tlast)
interface msix_msg_writer_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    modport master (output tdata, tvalid, tlast, input tready);
    modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/msix_msg_writer.sv
// msix_msg_writer: fetches an MSI-X table entry for a requested vector and emits one MWr TLP.
// Ports: clk, reset (sync, active-high); msix_interrupt/msix_vector in, msix_interrupt_ack out;
// cfg_bus_master_en gates new requests; tbl_rd_en/tbl_rd_addr out, tbl_rd_data in (1-cycle latency);
// tx (msix_msg_writer_if.master) carries the TLP; err_drop pulses with ack for out-of-range vectors.
// Define MSIX_MSG_64BIT_EN to fetch addr_hi and emit 4DW headers when addr_hi != 0.
module msix_msg_writer #(
    parameter int          NUM_MSIX     = 1,
    parameter logic [15:0] REQUESTER_ID = 16'h0,
    parameter logic [7:0]  TLP_TAG      = 8'h0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   msix_interrupt,
    input  logic [10:0]            msix_vector,
    output logic                   msix_interrupt_ack,
    input  logic                   cfg_bus_master_en,
    output logic                   tbl_rd_en,
    output logic [12:0]            tbl_rd_addr,
    input  logic [31:0]            tbl_rd_data,
    msix_msg_writer_if.master      tx,
    output logic                   err_drop
);
    typedef enum logic [1:0] {IDLE, FETCH, SEND, ACK} state_t;
    localparam logic [11:0] NUM_V = 12'(NUM_MSIX);
    state_t      state;
    logic [1:0]  fc;
    logic [2:0]  beat;
    logic [31:0] addr_lo;
    logic [31:0] addr_hi;
    logic [31:0] msg_data;
    logic        is4;
    logic [2:0]  last_beat;
    logic [2:0]  nxt;
    logic [31:0] hdr0;
    logic [31:0] nxt_dw;
    // addr_hi stays 0 in the 32-bit build, which collapses everything below to the 3DW format
    assign is4       = |addr_hi;
    assign last_beat = is4 ? 3'd4 : 3'd3;
    assign hdr0      = is4 ? 32'h6000_0001 : 32'h4000_0001;
    assign nxt       = beat + 3'd1;
    assign nxt_dw    = nxt == 3'd1 ? {REQUESTER_ID, TLP_TAG, 8'h0F} :
                       nxt == 3'd2 ? (is4 ? addr_hi : addr_lo) :
                       nxt == 3'd3 ? (is4 ? addr_lo : msg_data) : msg_data;
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            fc                 <= '0;
            beat               <= '0;
            addr_lo            <= '0;
            addr_hi            <= '0;
            msg_data           <= '0;
            tbl_rd_en          <= 1'b0;
            tbl_rd_addr        <= '0;
            tx.tdata           <= '0;
            tx.tvalid          <= 1'b0;
            tx.tlast           <= 1'b0;
            msix_interrupt_ack <= 1'b0;
            err_drop           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (msix_interrupt && cfg_bus_master_en) begin
                        if ({1'b0, msix_vector} >= NUM_V) begin
                            state              <= ACK;
                            msix_interrupt_ack <= 1'b1;
                            err_drop           <= 1'b1;
                        end else begin
                            state       <= FETCH;
                            tbl_rd_en   <= 1'b1;
                            tbl_rd_addr <= {msix_vector, 2'b00};
                            fc          <= '0;
                        end
                    end
                end
                // fc counts FETCH cycles; read data lands one cycle behind each strobe
                FETCH: begin
                    fc <= fc + 2'd1;
`ifdef MSIX_MSG_64BIT_EN
                    if (fc == 2'd0) tbl_rd_addr <= tbl_rd_addr + 13'd1;
                    if (fc == 2'd1) begin
                        addr_lo     <= {tbl_rd_data[31:2], 2'b00};
                        tbl_rd_addr <= tbl_rd_addr + 13'd1;
                    end
                    if (fc == 2'd2) begin
                        addr_hi   <= tbl_rd_data;
                        tbl_rd_en <= 1'b0;
                    end
                    if (fc == 2'd3) begin
                        msg_data  <= tbl_rd_data;
                        state     <= SEND;
                        tx.tvalid <= 1'b1;
                        tx.tdata  <= hdr0;
                        tx.tlast  <= 1'b0;
                        beat      <= '0;
                    end
`else
                    if (fc == 2'd0) tbl_rd_addr <= tbl_rd_addr + 13'd2;
                    if (fc == 2'd1) begin
                        addr_lo   <= {tbl_rd_data[31:2], 2'b00};
                        tbl_rd_en <= 1'b0;
                    end
                    if (fc == 2'd2) begin
                        msg_data  <= tbl_rd_data;
                        state     <= SEND;
                        tx.tvalid <= 1'b1;
                        tx.tdata  <= hdr0;
                        tx.tlast  <= 1'b0;
                        beat      <= '0;
                    end
`endif
                end
                SEND: begin
                    if (tx.tready) begin
                        if (beat == last_beat) begin
                            tx.tvalid          <= 1'b0;
                            tx.tlast           <= 1'b0;
                            state              <= ACK;
                            msix_interrupt_ack <= 1'b1;
                        end else begin
                            beat     <= nxt;
                            tx.tdata <= nxt_dw;
                            tx.tlast <= nxt == last_beat;
                        end
                    end
                end
                ACK: begin
                    msix_interrupt_ack <= 1'b0;
                    err_drop           <= 1'b0;
                    state              <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_msix_msg_writer.sv
// tb_msix_msg_writer: table-driven and scoreboarded checks of msix_msg_writer
module tb_msix_msg_writer;
    localparam int NUM = 4;
`ifdef MSIX_MSG_64BIT_EN
    localparam bit M64 = 1'b1;
`else
    localparam bit M64 = 1'b0;
`endif
    localparam int LAT = M64 ? 5 : 4;
    typedef struct {
        logic [10:0] vec;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [31:0] msg;
        bit          stall;
        bit          drop;
        int          nb;
    } rec_t;
    typedef struct {
        logic [31:0] d;
        logic        l;
    } beat_t;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        irq = 1'b0;
    logic        bme = 1'b0;
    logic [10:0] vec = '0;
    logic        ack;
    logic        rd_en;
    logic        drop;
    logic [12:0] rd_addr;
    logic [31:0] rd_data;
    logic [31:0] mem [0:63];
    beat_t       exp_q[$];
    logic [12:0] addr_q[$];
    rec_t        tbl [6];
    int          total = 0;
    int          passed = 0;
    int          acc = 0;
    bit          ack_exp = 1'b0;
    bit          mon_drop = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_d = '0;
    logic        prev_l = 1'b0;
    msix_msg_writer_if tx();
    always #5 clk = ~clk;
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr[5:0]];
    msix_msg_writer #(.NUM_MSIX(NUM), .REQUESTER_ID(16'hABCD), .TLP_TAG(8'h5A)) dut (
        .clk(clk), .reset(reset), .msix_interrupt(irq), .msix_vector(vec),
        .msix_interrupt_ack(ack), .cfg_bus_master_en(bme), .tbl_rd_en(rd_en),
        .tbl_rd_addr(rd_addr), .tbl_rd_data(rd_data), .tx(tx), .err_drop(drop)
    );
    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask
    task automatic expect_entry(input logic [10:0] v, input logic [31:0] lo, input logic [31:0] hi, input logic [31:0] msg);
        bit          is4;
        logic [12:0] base;
        is4  = M64 && hi != 32'h0;
        base = {v, 2'b00};
        addr_q.push_back(base);
        if (M64) addr_q.push_back(base + 13'd1);
        addr_q.push_back(base + 13'd2);
        exp_q.push_back('{d: is4 ? 32'h6000_0001 : 32'h4000_0001, l: 1'b0});
        exp_q.push_back('{d: {16'hABCD, 8'h5A, 8'h0F}, l: 1'b0});
        if (is4) exp_q.push_back('{d: hi, l: 1'b0});
        exp_q.push_back('{d: lo & 32'hFFFF_FFFC, l: 1'b0});
        exp_q.push_back('{d: msg, l: 1'b1});
    endtask
    task automatic monitor();
        logic [12:0] a;
        beat_t       b;
        if (rd_en) begin
            if (addr_q.size() == 0) chk(1'b0, "extra_rd", 32'(rd_addr), 32'h0);
            else begin
                a = addr_q.pop_front();
                chk(rd_addr == a, "rd_addr", 32'(rd_addr), 32'(a));
            end
        end
        if (prev_stall) chk(tx.tvalid && tx.tdata == prev_d && tx.tlast == prev_l, "stall_hold", tx.tdata, prev_d);
        if (ack || ack_exp) chk(ack == (ack_exp || mon_drop), "ack", 32'(ack), 32'(ack_exp || mon_drop));
        ack_exp = 1'b0;
        if (tx.tvalid && tx.tready) begin
            acc++;
            if (exp_q.size() == 0) chk(1'b0, "extra_beat", tx.tdata, 32'h0);
            else begin
                b = exp_q.pop_front();
                chk(tx.tdata == b.d && tx.tlast == b.l, "beat", {tx.tdata[31:1], tx.tlast}, {b.d[31:1], b.l});
                if (tx.tdata != b.d) $display("FAIL beat_data: got %h expected %h", tx.tdata, b.d);
            end
            if (tx.tlast) ack_exp = 1'b1;
        end
        prev_stall = tx.tvalid && !tx.tready;
        prev_d     = tx.tdata;
        prev_l     = tx.tlast;
    endtask
    task automatic run_case(input rec_t r, input bit chk_lat);
        int first;
        bit got;
        int idx;
        first = -1;
        got   = 1'b0;
        idx   = int'(r.vec) * 4;
        if (!r.drop) begin
            mem[idx]     = r.lo;
            mem[idx + 1] = r.hi;
            mem[idx + 2] = r.msg;
            expect_entry(r.vec, r.lo, r.hi, r.msg);
        end
        @(posedge clk);
        #1;
        irq       = 1'b1;
        bme       = 1'b1;
        vec       = r.vec;
        tx.tready = 1'b1;
        mon_drop  = r.drop;
        acc       = 0;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            monitor();
            if (tx.tvalid && first < 0) first = n;
            if (ack) begin
                got = 1'b1;
                chk(drop == r.drop, "err_drop", 32'(drop), 32'(r.drop));
            end
            @(posedge clk);
            #1;
            if (r.stall) tx.tready = ~tx.tready;
        end
        irq      = 1'b0;
        mon_drop = 1'b0;
        chk(got, "ack_seen", 32'(got), 32'h1);
        chk(acc == r.nb, "beat_count", 32'(acc), 32'(r.nb));
        chk(exp_q.size() == 0 && addr_q.size() == 0, "queues_drained", 32'(exp_q.size()), 32'(addr_q.size()));
        if (chk_lat && !r.drop) chk(first == LAT, "first_valid_cycle", 32'(first), 32'(LAT));
        @(negedge clk);
        monitor();
        chk(!ack && !drop, "ack_single", {30'h0, ack, drop}, 32'h0);
    endtask
    initial begin
        bit act;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        tx.tready = 1'b1;
        tbl[0] = '{11'd2, 32'hFEE0_0004, 32'h0000_0000, 32'h0000_4021, 1'b0, 1'b0, 4};
        tbl[1] = '{11'd1, 32'hFEE0_1007, 32'h0000_0001, 32'h0000_BEEF, 1'b0, 1'b0, M64 ? 5 : 4};
        tbl[2] = '{11'd3, 32'hFEE0_0008, 32'h0000_0000, 32'h1234_5678, 1'b1, 1'b0, 4};
        tbl[3] = '{11'd0, 32'hABCD_EF02, 32'h8000_0000, 32'hCAFE_F00D, 1'b1, 1'b0, M64 ? 5 : 4};
        tbl[4] = '{11'd7, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 0};
        tbl[5] = '{11'd4, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(ack == 1'b0, "rst_ack", 32'(ack), 32'h0);
        chk(rd_en == 1'b0, "rst_rd_en", 32'(rd_en), 32'h0);
        chk(rd_addr == 13'h0, "rst_rd_addr", 32'(rd_addr), 32'h0);
        chk(tx.tvalid == 1'b0, "rst_tvalid", 32'(tx.tvalid), 32'h0);
        chk(tx.tlast == 1'b0, "rst_tlast", 32'(tx.tlast), 32'h0);
        chk(tx.tdata == 32'h0, "rst_tdata", tx.tdata, 32'h0);
        chk(drop == 1'b0, "rst_err_drop", 32'(drop), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) run_case(tbl[i], 1'b1);
        // bus mastering off: request must sit untouched
        @(posedge clk);
        #1;
        bme = 1'b0;
        irq = 1'b1;
        vec = 11'd2;
        act = 1'b0;
        repeat (20) begin
            @(negedge clk);
            monitor();
            act = act | rd_en | tx.tvalid | ack;
        end
        chk(!act, "bme_blocked", 32'(act), 32'h0);
        run_case(tbl[0], 1'b1);
        // reset in the middle of a packet, request held across it
        expect_entry(11'd2, tbl[0].lo, tbl[0].hi, tbl[0].msg);
        @(posedge clk);
        #1;
        irq = 1'b1;
        bme = 1'b1;
        vec = 11'd2;
        tx.tready = 1'b1;
        acc = 0;
        for (int n = 0; n < 50 && acc < 2; n++) begin
            @(negedge clk);
            monitor();
        end
        chk(acc == 2, "reached_beat2", 32'(acc), 32'h2);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        @(negedge clk);
        chk({tx.tvalid, tx.tlast, rd_en, ack, drop} == 5'b0, "mid_rst_outputs", 32'({tx.tvalid, tx.tlast, rd_en, ack, drop}), 32'h0);
        exp_q.delete();
        addr_q.delete();
        ack_exp    = 1'b0;
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_case(tbl[0], 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
